wino_tile_gather: RTL and testbench

//  Upstream feeder for the Winograd BT*D*B input-transform stage. Accepts a raster-order

---
 rtl/wino_tile_gather_if.sv | 45 ++++
 rtl/wino_tile_gather.sv | 128 ++++++++++++
 tb/tb_wino_tile_gather.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wino_tile_gather_if.sv
// Purpose: bundles the pixel-stream input and the tile output of wino_tile_gather.
// Signals:
//   din, din_valid, din_ready   raster-order pixel stream (valid/ready)
//   dout0..dout11               tile words, dout(r*4+k) = tile row r, column k
//   tile_valid, tile_ready      tile output handshake
//   tile_last                   last tile of the frame, qualified by tile_valid
// Modports:
//   master  the side that produces pixels and consumes tiles (testbench / upstream)
//   slave   the tile gatherer itself
interface wino_tile_gather_if #(
  parameter int data_width = 18
);
  logic [data_width-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic [data_width-1:0] dout0;
  logic [data_width-1:0] dout1;
  logic [data_width-1:0] dout2;
  logic [data_width-1:0] dout3;
  logic [data_width-1:0] dout4;
  logic [data_width-1:0] dout5;
  logic [data_width-1:0] dout6;
  logic [data_width-1:0] dout7;
  logic [data_width-1:0] dout8;
  logic [data_width-1:0] dout9;
  logic [data_width-1:0] dout10;
  logic [data_width-1:0] dout11;
  logic                  tile_valid;
  logic                  tile_ready;
  logic                  tile_last;

  modport master (
    output din, din_valid, tile_ready,
    input  din_ready, tile_valid, tile_last,
    input  dout0, dout1, dout2, dout3, dout4, dout5,
    input  dout6, dout7, dout8, dout9, dout10, dout11
  );

  modport slave (
    input  din, din_valid, tile_ready,
    output din_ready, tile_valid, tile_last,
    output dout0, dout1, dout2, dout3, dout4, dout5,
    output dout6, dout7, dout8, dout9, dout10, dout11
  );
endinterface

// File: rtl/wino_tile_gather.sv
// Purpose: feeder for the Winograd input-transform stage. Takes a raster-order
// pixel stream of one channel and assembles 3-row x 4-column tiles that step
// 2 columns horizontally and 3 rows vertically. Rows 0 and 1 of each band are
// held in line buffers, row 2 is consumed on the fly through a 3-deep shift
// register, so a tile is complete on the beat carrying its bottom-right pixel.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   wino_tile_gather_if.slave: pixel stream in, 12-word tile out
module wino_tile_gather #(
  parameter int data_width = 18,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 6
) (
  input logic                clk,
  input logic                rst,
  wino_tile_gather_if.slave  bus
);

  localparam int BANDS = IMG_H / 3;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int BW    = (BANDS > 1) ? $clog2(BANDS) : 1;

  logic [CW-1:0]         col;
  logic [1:0]            rib;
  logic [BW-1:0]         band;

  logic [data_width-1:0] lb0 [IMG_W];
  logic [data_width-1:0] lb1 [IMG_W];
  logic [data_width-1:0] sr  [3];
  logic [data_width-1:0] tile_q [12];
  logic                  tile_valid_q;
  logic                  tile_last_q;

  logic                  beat;
  logic                  emit;
  logic                  col_last;
  logic                  band_last;

  // A stalled tile blocks input; a new tile may only be emitted once the
  // current one is being taken in the same cycle.
  assign bus.din_ready = ~tile_valid_q | bus.tile_ready;
  assign beat          = bus.din_valid & bus.din_ready;
  assign col_last      = (col == CW'(IMG_W - 1));
  assign band_last     = (band == BW'(BANDS - 1));
  assign emit          = beat && (rib == 2'd2) && col[0] && (col >= CW'(3));

  // Position counters: column within row, row within band, band within frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      rib  <= '0;
      band <= '0;
    end else if (beat) begin
      if (col_last) begin
        col <= '0;
        if (rib == 2'd2) begin
          rib  <= '0;
          band <= band_last ? '0 : band + BW'(1);
        end else begin
          rib <= rib + 2'd1;
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Pixel storage needs no reset: every word is written before it is read
  // within a band, so stale contents after reset are harmless.
  always_ff @(posedge clk) begin
    if (beat) begin
      if (rib == 2'd0) begin
        lb0[col] <= bus.din;
      end
      if (rib == 2'd1) begin
        lb1[col] <= bus.din;
      end
      if (rib == 2'd2) begin
        sr[0] <= sr[1];
        sr[1] <= sr[2];
        sr[2] <= bus.din;
      end
    end
  end

  // Output register: loaded only by an emitting beat, so it holds while the
  // downstream stalls (no beat can happen then). The last row of the tile is
  // the shift register (oldest first) plus the pixel arriving right now.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 12; k++) begin
        tile_q[k] <= '0;
      end
      tile_valid_q <= 1'b0;
      tile_last_q  <= 1'b0;
    end else if (emit) begin
      for (int k = 0; k < 4; k++) begin
        tile_q[k]     <= lb0[col - CW'(3) + CW'(k)];
        tile_q[4 + k] <= lb1[col - CW'(3) + CW'(k)];
      end
      tile_q[8]    <= sr[0];
      tile_q[9]    <= sr[1];
      tile_q[10]   <= sr[2];
      tile_q[11]   <= bus.din;
      tile_valid_q <= 1'b1;
      tile_last_q  <= band_last & col_last;
    end else if (bus.tile_ready) begin
      tile_valid_q <= 1'b0;
    end
  end

  assign bus.tile_valid = tile_valid_q;
  assign bus.tile_last  = tile_last_q;
  assign bus.dout0      = tile_q[0];
  assign bus.dout1      = tile_q[1];
  assign bus.dout2      = tile_q[2];
  assign bus.dout3      = tile_q[3];
  assign bus.dout4      = tile_q[4];
  assign bus.dout5      = tile_q[5];
  assign bus.dout6      = tile_q[6];
  assign bus.dout7      = tile_q[7];
  assign bus.dout8      = tile_q[8];
  assign bus.dout9      = tile_q[9];
  assign bus.dout10     = tile_q[10];
  assign bus.dout11     = tile_q[11];

endmodule

// File: tb/tb_wino_tile_gather.sv
// Purpose: self-checking bench for wino_tile_gather (IMG_W=8, IMG_H=6).
// Expected tiles are computed from the pixel formula when the completing
// pixel is driven, queued, and compared when the tile is handed over.
// Ports: none (top-level bench).
module tb_wino_tile_gather;

  localparam int DW    = 18;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;

  typedef struct packed {
    logic                 last;
    logic [31:0]          cyc;
    logic [11:0][DW-1:0]  w;
  } tile_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wino_tile_gather_if #(.data_width(DW)) bus();

  wino_tile_gather #(
    .data_width(DW),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  tile_t       exp_q[$];
  int          tile_count = 0;
  int          last_count = 0;
  int          stall_cycles = 0;
  bit          lat_check = 1'b0;
  bit          cap_arm = 1'b0;
  bit          stall_arm = 1'b0;
  bit          prev_stall = 1'b0;
  tile_t       cap;
  tile_t       held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c, input bit neg);
    int v;
    v = r * 16 + c;
    if (neg) v = -v;
    return v[DW-1:0];
  endfunction

  function automatic tile_t curTile();
    tile_t t;
    t.last  = bus.tile_last;
    t.cyc   = cyc;
    t.w[0]  = bus.dout0;
    t.w[1]  = bus.dout1;
    t.w[2]  = bus.dout2;
    t.w[3]  = bus.dout3;
    t.w[4]  = bus.dout4;
    t.w[5]  = bus.dout5;
    t.w[6]  = bus.dout6;
    t.w[7]  = bus.dout7;
    t.w[8]  = bus.dout8;
    t.w[9]  = bus.dout9;
    t.w[10] = bus.dout10;
    t.w[11] = bus.dout11;
    return t;
  endfunction

  // Drive one pixel and hold it until it is accepted; queue its tile if it completes one.
  task automatic applyStimulus(input logic [DW-1:0] v, input bit push, input tile_t e);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    bus.din       = v;
    bus.din_valid = 1'b1;
    @(negedge clk);
    while (!bus.din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.din_ready) begin
      checkOutput("din_ready_timeout", 32'd0, 32'd1);
    end else if (push) begin
      e.cyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.din       = '0;
  endtask

  task automatic streamFrame(input bit neg, input bit gaps, input int npix);
    for (int p = 0; p < npix; p++) begin
      int    r;
      int    c;
      bit    em;
      tile_t e;
      r  = p / IMG_W;
      c  = p % IMG_W;
      em = (r % 3 == 2) && (c % 2 == 1) && (c >= 3);
      e  = '0;
      if (em) begin
        for (int k = 0; k < 4; k++) begin
          e.w[k]     = pix(r - 2, c - 3 + k, neg);
          e.w[4 + k] = pix(r - 1, c - 3 + k, neg);
          e.w[8 + k] = pix(r,     c - 3 + k, neg);
        end
        e.last = (r / 3 == IMG_H / 3 - 1) && (c == IMG_W - 1);
      end
      if (gaps && ($urandom_range(0, 1) == 1)) idleCycle();
      applyStimulus(pix(r, c, neg), em, e);
    end
  endtask

  task automatic drainOut();
    idleCycle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: compare handed-over tiles, check holding behaviour while stalled.
  always @(negedge clk) begin
    tile_t got;
    tile_t e;
    if (!rst) begin
      got = curTile();
      if (bus.tile_valid && !bus.tile_ready) begin
        stall_cycles++;
        checkOutput("stall_din_ready", {31'd0, bus.din_ready}, 32'd0);
        if (prev_stall) begin
          checkOutput("stall_hold", {31'd0, ({got.last, got.w} == {held.last, held.w})}, 32'd1);
        end
        held       = got;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.tile_valid && bus.tile_ready) begin
        tile_count++;
        if (got.last) last_count++;
        if (cap_arm) begin
          cap     = got;
          cap_arm = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_tile", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("tile%0d_dout%0d", tile_count, k), {14'd0, got.w[k]}, {14'd0, e.w[k]});
          end
          checkOutput($sformatf("tile%0d_last", tile_count), {31'd0, got.last}, {31'd0, e.last});
          if (lat_check) begin
            checkOutput($sformatf("tile%0d_latency", tile_count), cyc, e.cyc + 1);
          end
        end
      end
    end
  end

  // Downstream back-pressure: when armed, refuse the next tile for 5 cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_arm && bus.tile_valid) begin
        stall_arm      = 1'b0;
        bus.tile_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.tile_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.tile_ready = 1'b1;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tile_valid", {31'd0, bus.tile_valid}, 32'd0);
    checkOutput("rst_tile_last",  {31'd0, bus.tile_last},  32'd0);
    checkOutput("rst_dout0",      {14'd0, bus.dout0},      32'd0);
    checkOutput("rst_dout11",     {14'd0, bus.dout11},     32'd0);
    checkOutput("rst_din_ready",  {31'd0, bus.din_ready},  32'd1);
    rst = 1'b0;

    $display("[TB] gap-free frame");
    tile_count = 0; last_count = 0; lat_check = 1'b1; cap_arm = 1'b1;
    streamFrame(1'b0, 1'b0, IMG_W * IMG_H);
    drainOut();
    checkOutput("f1_tiles", tile_count, 6);
    checkOutput("f1_last_count", last_count, 1);
    checkOutput("f1_queue_empty", exp_q.size(), 0);
    checkOutput("f1_first_dout0",  {14'd0, cap.w[0]},  32'd0);
    checkOutput("f1_first_dout4",  {14'd0, cap.w[4]},  32'd16);
    checkOutput("f1_first_dout8",  {14'd0, cap.w[8]},  32'd32);
    checkOutput("f1_first_dout11", {14'd0, cap.w[11]}, 32'd35);

    $display("[TB] stalled first tile");
    tile_count = 0; lat_check = 1'b0; stall_cycles = 0; stall_arm = 1'b1;
    streamFrame(1'b0, 1'b0, IMG_W * IMG_H);
    drainOut();
    checkOutput("stall_tiles", tile_count, 6);
    checkOutput("stall_cycles", stall_cycles, 5);
    checkOutput("stall_queue_empty", exp_q.size(), 0);

    $display("[TB] two frames with random gaps");
    tile_count = 0; last_count = 0; lat_check = 1'b1;
    streamFrame(1'b0, 1'b1, IMG_W * IMG_H);
    streamFrame(1'b0, 1'b1, IMG_W * IMG_H);
    drainOut();
    checkOutput("gap_tiles", tile_count, 12);
    checkOutput("gap_last_count", last_count, 2);
    checkOutput("gap_queue_empty", exp_q.size(), 0);

    $display("[TB] reset mid-frame");
    streamFrame(1'b0, 1'b0, 21);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_tile_valid", {31'd0, bus.tile_valid}, 32'd0);
    checkOutput("midrst_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    prev_stall = 1'b0;
    tile_count = 0; cap_arm = 1'b1;
    streamFrame(1'b0, 1'b0, IMG_W * IMG_H);
    drainOut();
    checkOutput("midrst_tiles", tile_count, 6);
    checkOutput("midrst_first_dout0",  {14'd0, cap.w[0]},  32'd0);
    checkOutput("midrst_first_dout4",  {14'd0, cap.w[4]},  32'd16);
    checkOutput("midrst_first_dout11", {14'd0, cap.w[11]}, 32'd35);

    $display("[TB] negative pixel values");
    tile_count = 0; cap_arm = 1'b1;
    streamFrame(1'b1, 1'b0, IMG_W * IMG_H);
    drainOut();
    checkOutput("neg_tiles", tile_count, 6);
    checkOutput("neg_first_dout0",  {14'd0, cap.w[0]},  32'd0);
    checkOutput("neg_first_dout1",  {14'd0, cap.w[1]},  {14'd0, 18'h3FFFF});
    checkOutput("neg_first_dout11", {14'd0, cap.w[11]}, {14'd0, 18'h3FFDD});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
